// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between two requesters (master 0 is
//   the core data port, master 1 a loader/DMA engine). Ownership is held in
//   a register. Acquiring the memory from idle costs one cycle. Hand-over
//   between masters costs no cycle when the owner runs out of burst budget.
//   Fairness is round-robin, and one owner gets at most MAX_BURST beats while
//   the other master waits.
//
// Ports
//   clk                     clock, rising edge
//   rst                     synchronous reset, active low
//   m{0,1}_req              access request, held stable until ack
//   m{0,1}_we               1 = write, 0 = read
//   m{0,1}_addr / _wdata    access address / write data
//   m{0,1}_rdata            read data, valid with ack on a read
//   m{0,1}_ack              access performed this cycle
//   mem_ce / mem_we         memory chip enable / write enable
//   mem_addr / mem_wdata    memory address / write data
//   mem_rdata               memory read data, combinational from mem_addr
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | nobody owns the memory; arbitrate this cycle
// OWN0  | master 0 owns; its request is serviced
// OWN1  | master 1 owns; its request is serviced
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last;
  logic            w_last_nxt;
  logic [BW-1:0]   r_beat;
  logic [BW-1:0]   w_beat_nxt;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_ack0;
  logic            w_ack1;
  logic [BW-1:0]   w_beat_inc;

  // Beat counter saturates so a lone owner can stream indefinitely; the
  // budget check only matters while the other master is waiting.
  assign w_beat_inc = (r_beat == LAST_BEAT) ? r_beat : r_beat + BW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_last_nxt  = r_last;
    w_beat_nxt  = '0;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) begin
          w_state_nxt = r_last ? OWN0 : OWN1;
        end else if (m0_req) begin
          w_state_nxt = OWN0;
        end else if (m1_req) begin
          w_state_nxt = OWN1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      OWN0: begin
        if (m0_req) begin
          w_grant0   = 1'b1;
          w_last_nxt = 1'b0;
          if ((r_beat == LAST_BEAT) && m1_req) begin
            w_state_nxt = OWN1;
          end else begin
            w_state_nxt = OWN0;
            w_beat_nxt  = w_beat_inc;
          end
        end else begin
          w_state_nxt = m1_req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (m1_req) begin
          w_grant1   = 1'b1;
          w_last_nxt = 1'b1;
          if ((r_beat == LAST_BEAT) && m0_req) begin
            w_state_nxt = OWN0;
          end else begin
            w_state_nxt = OWN1;
            w_beat_nxt  = w_beat_inc;
          end
        end else begin
          w_state_nxt = m0_req ? OWN0 : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Reset must block the access in its own cycle, so the enables are gated
  // combinationally rather than waiting for the state register to clear.
  assign w_ack0 = w_grant0 & rst;
  assign w_ack1 = w_grant1 & rst;

  assign m0_ack    = w_ack0;
  assign m1_ack    = w_ack1;
  assign mem_ce    = w_ack0 | w_ack1;
  assign mem_we    = (w_ack0 & m0_we) | (w_ack1 & m1_we);
  assign mem_addr  = w_grant0 ? m0_addr  : (w_grant1 ? m1_addr  : '0);
  assign mem_wdata = w_grant0 ? m0_wdata : (w_grant1 ? m1_wdata : '0);
  assign m0_rdata  = w_ack0 ? mem_rdata : '0;
  assign m1_rdata  = w_ack1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Drives both masters from per-master transaction queues, predicts every
//   ack with a cycle-level ownership model and a shadow memory, and checks
//   the DUT from an independent negedge monitor.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i) * 32'h0101_0101);
  endfunction

  // Memory seen by the DUT: 16 words, written on the edge ending a write ack.
  logic [31:0] tb_mem [16];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_ce && mem_we) begin
      tb_mem[mem_addr[5:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = tb_mem[mem_addr[5:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
    int          hold;
  } txn_t;

  typedef struct {
    int          cyc;
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  txn_t        mq [2][$];
  exp_t        sb [$];
  logic [31:0] shadow [16];
  int          presented [2];
  int          acks_seen [2];
  logic        rst_drv;
  int          checks = 0;
  int          errors = 0;

  // Reference model: who owns the memory, how many beats it has had in the
  // current tenure, and who was served last.
  int own  = -1;
  int run  = 0;
  int last = 1;

  task automatic add(input int m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int gap, input int hold);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.gap = gap; t.hold = hold;
    mq[m].push_back(t);
  endtask

  task automatic tick();
    logic r [2];
    txn_t cur [2];
    txn_t t;
    exp_t e;
    int   ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      r[i] = 1'b0;
      cur[i].we = 1'b0; cur[i].addr = '0; cur[i].wdata = '0;
      cur[i].gap = 0; cur[i].hold = 0;
      if (mq[i].size() > 0) begin
        t = mq[i].pop_front();
        if (t.gap > 0) t.gap--;
        else r[i] = 1'b1;
        mq[i].push_front(t);
        cur[i] = t;
      end
    end
    rst      = rst_drv;
    m0_req   = r[0];
    m0_we    = r[0] ? cur[0].we    : 1'($urandom_range(0, 1));
    m0_addr  = r[0] ? cur[0].addr  : $urandom;
    m0_wdata = r[0] ? cur[0].wdata : $urandom;
    m1_req   = r[1];
    m1_we    = r[1] ? cur[1].we    : 1'($urandom_range(0, 1));
    m1_addr  = r[1] ? cur[1].addr  : $urandom;
    m1_wdata = r[1] ? cur[1].wdata : $urandom;

    ack = -1;
    if (!rst_drv) begin
      own = -1; run = 0; last = 1;
    end else if (own < 0) begin
      if (r[0] && r[1]) own = (last == 0) ? 1 : 0;
      else if (r[0])    own = 0;
      else if (r[1])    own = 1;
      run = 0;
    end else if (r[own]) begin
      ack  = own;
      last = own;
      run++;
      if (run >= MB && r[1-own]) begin
        own = 1 - own;
        run = 0;
      end
    end else begin
      own = r[1-own] ? 1 - own : -1;
      run = 0;
    end

    if (ack >= 0) begin
      e.cyc = cyc; e.m = ack; e.we = cur[ack].we;
      e.addr = cur[ack].addr; e.wdata = cur[ack].wdata;
      e.rdata = shadow[cur[ack].addr[5:2]];
      if (cur[ack].we) shadow[cur[ack].addr[5:2]] = cur[ack].wdata;
      sb.push_back(e);
      void'(mq[ack].pop_front());
      acks_seen[ack]++;
      presented[ack] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (r[i] && i != ack) begin
        presented[i]++;
        if (cur[i].hold > 0 && presented[i] >= cur[i].hold) begin
          t = mq[i].pop_front();
          t.hold = 0; t.gap = 1;
          mq[i].push_front(t);
          presented[i] = 0;
        end
      end
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((mq[0].size() > 0 || mq[1].size() > 0) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (mq[0].size() > 0 || mq[1].size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending m0=%0d m1=%0d required 0", mq[0].size(), mq[1].size());
      mq[0].delete();
      mq[1].delete();
    end
    repeat (3) tick();
  endtask

  // Monitor: every cycle either the predicted ack appears or the memory is idle.
  int wait_c [2] = '{0, 0};
  always @(negedge clk) begin
    int   got;
    logic rq, ak;
    exp_t e;
    got = m0_ack ? 0 : (m1_ack ? 1 : -1);
    checks++;
    if (m0_ack && m1_ack) begin
      errors++;
      $display("FAIL both_ack cyc=%0d both masters acked, required at most one", cyc);
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL stale_exp cyc=%0d expected ack m%0d never seen", e.cyc, e.m);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checks++;
      if (got != e.m) begin
        errors++;
        $display("FAIL ack_who cyc=%0d got m%0d required m%0d", cyc, got, e.m);
      end else begin
        checks++;
        if (mem_ce !== 1'b1 || mem_we !== e.we || mem_addr !== e.addr ||
            (e.we && mem_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL mem_port cyc=%0d ce=%0b we=%0b addr=%h wdata=%h required ce=1 we=%0b addr=%h wdata=%h",
                   cyc, mem_ce, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
        end
        if (!e.we) begin
          checks++;
          if (((e.m == 0) ? m0_rdata : m1_rdata) !== e.rdata) begin
            errors++;
            $display("FAIL rdata cyc=%0d m%0d got %h required %h", cyc, e.m,
                     (e.m == 0) ? m0_rdata : m1_rdata, e.rdata);
          end
        end
      end
    end else begin
      checks++;
      if (got >= 0 || mem_ce !== 1'b0 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL idle_port cyc=%0d ack=m%0d ce=%0b we=%0b required no access", cyc, got, mem_ce, mem_we);
      end
    end
    checks++;
    if ((!m0_ack && m0_rdata !== '0) || (!m1_ack && m1_rdata !== '0)) begin
      errors++;
      $display("FAIL rdata_zero cyc=%0d m0=%h m1=%h required 0 when not acked", cyc, m0_rdata, m1_rdata);
    end
    for (int m = 0; m < 2; m++) begin
      rq = (m == 0) ? m0_req : m1_req;
      ak = (m == 0) ? m0_ack : m1_ack;
      if (rst !== 1'b1 || rq !== 1'b1) begin
        wait_c[m] = 0;
      end else if (ak) begin
        checks++;
        if (wait_c[m] > MB + 1) begin
          errors++;
          $display("FAIL wait_bound cyc=%0d m%0d waited %0d required <= %0d", cyc, m, wait_c[m], MB + 1);
        end
        wait_c[m] = 0;
      end else begin
        wait_c[m]++;
      end
    end
  end

  initial begin
    int base;
    int n;
    rst = 1'b0; rst_drv = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    presented = '{0, 0};
    acks_seen = '{0, 0};
    for (int i = 0; i < 16; i++) shadow[i] = init_word(i);

    // Reset with both masters requesting and m0 writing: nothing may happen.
    add(0, 1'b1, 32'h20, 32'hCAFE_0001, 0, 0);
    add(1, 1'b0, 32'h24, 32'h0, 0, 0);
    repeat (3) tick();
    rst_drv = 1'b1;
    drain(50);

    // Single read from idle.
    repeat (2) tick();
    add(0, 1'b0, 32'h10, 32'h0, 0, 0);
    drain(20);

    // Tie right after reset, then release hand-over.
    rst_drv = 1'b0; tick(); rst_drv = 1'b1;
    add(0, 1'b0, 32'h08, 32'h0, 0, 0);
    add(1, 1'b0, 32'h0C, 32'h0, 0, 0);
    drain(20);

    // Burst fairness: m0 streams writes, m1 holds reads.
    for (int i = 0; i < 8; i++) add(0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0, 0);
    for (int i = 0; i < 6; i++) add(1, 1'b0, 32'(32 + i * 4), 32'h0, 0, 0);
    drain(60);

    // Saturation: lone owner streams without hand-over.
    for (int i = 0; i < 10; i++) add(0, 1'b0, 32'((i % 16) * 4), 32'h0, 0, 0);
    drain(40);

    // Reset during m1's second beat.
    base = acks_seen[1];
    for (int i = 0; i < 6; i++) add(1, 1'b1, 32'(16 + i * 4), 32'hB000_0000 + 32'(i), 0, 0);
    n = 0;
    while (acks_seen[1] - base < 1 && n < 20) begin tick(); n++; end
    rst_drv = 1'b0;
    add(0, 1'b1, 32'h3C, 32'hC0DE_0000, 0, 0);
    tick();
    tick();
    rst_drv = 1'b1;
    drain(60);

    // Randomized traffic with gaps, aborts and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (mq[i].size() < 2 && $urandom_range(0, 3) != 0)
          add(i, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      rst_drv = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst_drv = 1'b1;
    drain(300);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover %0d expected acks unseen, required 0", sb.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (tb_mem[i] !== shadow[i]) begin
        errors++;
        $display("FAIL mem_final word %0d got %h required %h", i, tb_mem[i], shadow[i]);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the core's data port (master 0) and a second requester such as a loader or DMA engine (master 1). Sits between the requesters and the data memory's ce/we/addr/data_i/data_o port. Ownership is registered: one cycle to acquire from idle, no bubble on hand-over. Fairness is round-robin with a bounded burst length.

## Interface
Parameters:
- ADDR_W, 32, address width of masters and memory port
- DATA_W, 32, data width
- MAX_BURST, 4, max consecutive acked beats for one owner while the other master waits (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the rising edge of clk)
- m0_req  in  1  master 0 access request; held with we/addr/wdata stable until m0_ack
- m0_we  in  1  master 0 write enable (1=write, 0=read)
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_rdata  out  DATA_W  master 0 read data, valid when m0_ack && !m0_we
- m0_ack  out  1  master 0 access performed this cycle
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1
- mem_ce  out  1  memory chip enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, last (last master served, reset 1), beat_cnt (width clog2(MAX_BURST), min 1).
- Access: in OWNk with mk_req=1: mem_ce=1; mem_we/addr/wdata = master k's; mk_ack=1; mk_rdata=mem_rdata. All combinational from state and inputs.
- Non-owner: ack=0, rdata=0. In IDLE, and in OWNk with mk_req=0: mem_ce=mem_we=0, mem_addr=mem_wdata=0.
- rst==0 gates mem_ce, mem_we, both acks to 0 combinationally in that cycle; no write can occur during reset.
- IDLE: neither req → stay. Only mk_req → OWNk. Both → OWN of master != last. beat_cnt←0.
- OWNk, mk_req=1 (beat acked): last←k. If beat_cnt==MAX_BURST-1 and other req=1 → OWN_other, beat_cnt←0. Otherwise stay; beat_cnt←beat_cnt+1, saturating at MAX_BURST-1.
- OWNk, mk_req=0: other req=1 → OWN_other, else → IDLE; beat_cnt←0.
- Requester dropping req without ack (abort) is legal; no memory access is issued for it.
- Unused state encodings → IDLE.

## Timing
- Reset values: state=IDLE, last=1, beat_cnt=0; all outputs 0.
- Latency from IDLE: req at cycle T → ack at T+1 (one arbitration cycle).
- Continuing owner: back-to-back acks every cycle while req held; master presents next request the cycle after ack.
- Hand-over at budget: other master's first ack in the cycle immediately after the owner's MAX_BURST-th beat; no dead cycle.
- Release hand-over (owner req low in OWNk): one empty cycle, then other master acked.
- Writes take effect at the rising edge ending the ack cycle; reads return in the ack cycle.
- Worst-case wait for a requester holding req: MAX_BURST+1 cycles.
- Reset mid-burst: ownership lost; beat in the reset cycle not acked and not written; from IDLE after reset, m0 wins a tie.

## Test plan
- Reset: rst=0 with both req=1, m0_we=1 → mem_ce=0, mem_we=0, acks=0 during reset; state IDLE afterwards.
- Single read: m0 reads addr 0x10 (mem returns 0xDEADBEEF) from IDLE at cycle T → m0_ack=1 and m0_rdata=0xDEADBEEF at T+1 only; m1_ack=0 throughout.
- Tie after reset: m0 and m1 req at same cycle → m0 acked first; after m0 releases, m1 acked after one empty cycle.
- Burst fairness, MAX_BURST=4: m0 streams writes 0x0..0x1C, m1 holds read req → m0 gets 4 acks, m1 acked next cycle, continues up to 4 beats, then m0 resumes.
- Saturation: only m0 requests for 10 cycles → 10 consecutive acks; beat_cnt saturates at 3, no hand-over.
- Reset mid-burst: assert rst=0 during m1's 2nd beat → no write in that cycle; after release with both req, m0 wins.
